main_mem_sequencer: RTL and testbench
=====================================

// Module: main_mem_sequencer
// PURPOSE
//  Hardware-side driver for the HLS top `main`; the synthesizable counterpart of the simulation bench.
//  Preloads `main` internal memory through its slave RAM port from a byte stream, then pulses start_port.
//  Measures run cycles until done_port, then reads the result region back out as a byte stream.
//  Sits between the host byte link (UART/DMA adapter) and `main`; uses slave channel 0 only.
// PARAMETERS
//  BASE_ADDR    256        byte address of first preload/readback location (matches MEM_var base)
//  LOAD_BYTES   400        bytes written before start (1..1023)
//  READ_BYTES   400        bytes read back after done (1..1023)
//  TIMEOUT      200000000  max run cycles before fault (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clock           in   1    system clock, all logic on rising edge
//  reset           in   1    asynchronous, active-low reset
//  go              in   1    level; sampled in IDLE/FIN to begin a new run
//  ld_valid        in   1    preload byte valid
//  ld_ready        out  1    preload byte accepted when ld_valid&ld_ready
//  ld_data         in   8    preload byte
//  rd_valid        out  1    readback byte valid
//  rd_ready        in   1    consumer accepts readback byte
//  rd_data         out  8    readback byte
//  start_port      out  1    one-cycle start pulse to `main`
//  done_port       in   1    completion from `main`
//  S_oe_ram        out  2    read enable per channel ([1] tied 0)
//  S_we_ram        out  2    write enable per channel ([1] tied 0)
//  S_addr_ram      out  20   {ch1,ch0} 10-bit byte addresses ([19:10] tied 0)
//  S_Wdata_ram     out  128  {ch1,ch0} 64-bit write data; byte in [7:0], rest 0
//  S_data_ram_size out  14   {ch1,ch0} access size in bits; ch0 = 7'd8 when oe/we, else 0
//  Sout_Rdata_ram  in   128  read data; byte taken from [7:0]
//  Sout_DataRdy    in   2    read data ready; only [0] used
//  busy            out  1    high in LOAD..READ
//  run_done        out  1    high in FIN
//  fault           out  1    high in FAULT (timeout)
//  cycles          out  32   latched run length
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (ld_ready, rd_valid, start_port, S_* , busy, run_done, fault, cycles).
//  IDLE: go=1 -> LOAD, byte index i=0. FIN/FAULT: go=1 -> LOAD (i=0, cycles kept until next latch).
//  LOAD: ld_ready=1; on handshake drive we[0]=1, addr=BASE_ADDR+i, Wdata[7:0]=ld_data, size=8, same cycle
//   (write is registered into `main` at next edge); i++; after byte LOAD_BYTES-1 -> START. Max 1 byte/cycle.
//  START: start_port=1 for exactly one cycle; run counter=1 -> RUN.
//  RUN: counter++ each cycle; done_port=1 -> latch cycles=counter, -> READ (i=0). done_port ignored
//   in every other state. cycles = clocks from start_port cycle to done_port cycle inclusive (same rule
//   as the bench: start-to-done back-to-back gives 2). Counter saturates at 2^32-1, never wraps.
//  READ sub-steps: RQ drive oe[0]=1, addr=BASE_ADDR+i, size=8 for one cycle -> RW wait Sout_DataRdy[0];
//   capture Sout_Rdata_ram[7:0] into rd_data, rd_valid=1 -> RH hold rd_data stable until rd_ready;
//   on handshake i++; i==READ_BYTES -> FIN else RQ. Only one outstanding read. DataRdy outside RW ignored.
//  FIN: run_done=1, busy=0; S_* idle (all 0).
//  ld_valid outside LOAD and rd_ready outside RH have no effect. reset low at any point -> IDLE
//   immediately, aborts run, start_port never re-issued; `main` must share the same reset.
//  Address arithmetic: BASE_ADDR+i computed 10-bit; parameters sized so no wrap (check in elaboration).
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: in RUN, counter==TIMEOUT without done_port -> FAULT; fault=1, cycles=TIMEOUT,
//   no readback; leave via go (new LOAD) or reset.
//  SEQ_TIMEOUT_EN undefined: no watchdog, RUN waits indefinitely; FAULT unreachable, fault tied 0.
// TESTING
//  1 Reset mid-LOAD after 10 bytes -> all outputs 0, IDLE; next go reloads from addr 256.
//  2 LOAD_BYTES=4, bytes 0x1E,0x05,0x63,0x00 back-to-back -> we[0] on 4 consecutive cycles, addr 256..259.
//  3 Model raises done_port 2 cycles after start_port -> cycles=3; done_port held 5 cycles -> latched once.
//  4 READ_BYTES=4, DataRdy 2 cycles after oe, rd_ready stalled 3 cycles -> rd_data stable, 4 bytes in order.
//  5 SEQ_TIMEOUT_EN, TIMEOUT=50, done never -> fault=1 at cycle 50, cycles=50, no oe issued.
//  6 ld_valid toggling every other cycle -> exactly LOAD_BYTES writes, single start_port pulse.

Source files
------------

// File: rtl/main_mem_sequencer.sv
// main_mem_sequencer: hardware driver for the HLS top `main`.
// Preloads `main` memory through slave RAM channel 0 from a byte stream. It then pulses
// start_port and counts run cycles until done_port. Finally it reads the result region back
// out as a byte stream.
// Optional watchdog: define SEQ_TIMEOUT_EN to move RUN to FAULT after TIMEOUT cycles.
module main_mem_sequencer #(
  parameter int unsigned BASE_ADDR  = 256,
  parameter int unsigned LOAD_BYTES = 400,
  parameter int unsigned READ_BYTES = 400,
  parameter int unsigned TIMEOUT    = 200000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         go,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [7:0]   ld_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [7:0]   rd_data,
  output logic         start_port,
  input  logic         done_port,
  output logic [1:0]   S_oe_ram,
  output logic [1:0]   S_we_ram,
  output logic [19:0]  S_addr_ram,
  output logic [127:0] S_Wdata_ram,
  output logic [13:0]  S_data_ram_size,
  input  logic [127:0] Sout_Rdata_ram,
  input  logic [1:0]   Sout_DataRdy,
  output logic         busy,
  output logic         run_done,
  output logic         fault,
  output logic [31:0]  cycles
);

  // Parameter sanity: byte counts must fit the 10-bit index and the address must not wrap.
  if (LOAD_BYTES < 1 || LOAD_BYTES > 1023) begin : g_bad_load_bytes
    $error("main_mem_sequencer: LOAD_BYTES must be in 1..1023");
  end
  if (READ_BYTES < 1 || READ_BYTES > 1023) begin : g_bad_read_bytes
    $error("main_mem_sequencer: READ_BYTES must be in 1..1023");
  end
  if (BASE_ADDR + LOAD_BYTES > 1024) begin : g_bad_load_range
    $error("main_mem_sequencer: BASE_ADDR + LOAD_BYTES exceeds 10-bit address space");
  end
  if (BASE_ADDR + READ_BYTES > 1024) begin : g_bad_read_range
    $error("main_mem_sequencer: BASE_ADDR + READ_BYTES exceeds 10-bit address space");
  end

  localparam logic [9:0] BaseAddr = 10'(BASE_ADDR);
  localparam logic [9:0] LastLoad = 10'(LOAD_BYTES - 1);
  localparam logic [9:0] LastRead = 10'(READ_BYTES - 1);
  localparam logic [6:0] ByteSize = 7'd8;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StRq,     // issue one read request
    StRw,     // wait for read data ready
    StRh,     // hold byte until consumer accepts
    StFin,
    StFault
  } state_e;

  state_e      r_state, w_state_d;
  logic [9:0]  r_idx, w_idx_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [31:0] r_cycles, w_cycles_d;
  logic [7:0]  r_rd_data, w_rd_data_d;

  logic        w_ld_ready;
  logic        w_start;
  logic        w_we0;
  logic        w_oe0;
  logic [9:0]  w_addr0;
  logic [7:0]  w_wdata0;
  logic [9:0]  w_cur_addr;
  logic [31:0] w_cnt_inc;

  assign w_cur_addr = BaseAddr + r_idx;
  // Run counter saturates instead of wrapping.
  assign w_cnt_inc  = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_cycles  <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_cnt     <= w_cnt_d;
      r_cycles  <= w_cycles_d;
      r_rd_data <= w_rd_data_d;
    end
  end

  // Next-state logic and channel-0 RAM strobes.
  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_cnt_d     = r_cnt;
    w_cycles_d  = r_cycles;
    w_rd_data_d = r_rd_data;
    w_ld_ready  = 1'b0;
    w_start     = 1'b0;
    w_we0       = 1'b0;
    w_oe0       = 1'b0;
    w_addr0     = '0;
    w_wdata0    = '0;

    unique case (r_state)
      StIdle: begin
        if (go) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
        end
      end

      StLoad: begin
        w_ld_ready = 1'b1;
        // Write goes out in the handshake cycle itself; `main` registers it at the edge.
        if (ld_valid) begin
          w_we0    = 1'b1;
          w_addr0  = w_cur_addr;
          w_wdata0 = ld_data;
          if (r_idx == LastLoad) begin
            w_state_d = StStart;
            w_idx_d   = '0;
          end else begin
            w_idx_d = r_idx + 10'd1;
          end
        end
      end

      StStart: begin
        w_start   = 1'b1;
        // The start cycle itself counts as cycle 1.
        w_cnt_d   = 32'd1;
        w_state_d = StRun;
      end

      StRun: begin
        w_cnt_d = w_cnt_inc;
        if (done_port) begin
          w_cycles_d = w_cnt_inc;
          w_idx_d    = '0;
          w_state_d  = StRq;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (w_cnt_inc >= TIMEOUT) begin
          w_cycles_d = 32'(TIMEOUT);
          w_state_d  = StFault;
        end
`endif
      end

      StRq: begin
        w_oe0     = 1'b1;
        w_addr0   = w_cur_addr;
        w_state_d = StRw;
      end

      StRw: begin
        if (Sout_DataRdy[0]) begin
          w_rd_data_d = Sout_Rdata_ram[7:0];
          w_state_d   = StRh;
        end
      end

      StRh: begin
        if (rd_ready) begin
          if (r_idx == LastRead) begin
            w_state_d = StFin;
          end else begin
            w_idx_d   = r_idx + 10'd1;
            w_state_d = StRq;
          end
        end
      end

      StFin, StFault: begin
        if (go) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  assign ld_ready        = w_ld_ready;
  assign start_port      = w_start;
  assign rd_valid        = (r_state == StRh);
  assign rd_data         = r_rd_data;
  assign S_oe_ram        = {1'b0, w_oe0};
  assign S_we_ram        = {1'b0, w_we0};
  assign S_addr_ram      = {10'd0, w_addr0};
  assign S_Wdata_ram     = {64'd0, 56'd0, w_wdata0};
  assign S_data_ram_size = {7'd0, (w_oe0 || w_we0) ? ByteSize : 7'd0};
  assign busy            = (r_state == StLoad) || (r_state == StStart) || (r_state == StRun) ||
                           (r_state == StRq)   || (r_state == StRw)    || (r_state == StRh);
  assign run_done        = (r_state == StFin);
  assign cycles          = r_cycles;

`ifdef SEQ_TIMEOUT_EN
  assign fault = (r_state == StFault);
  logic w_unused;
  assign w_unused = ^{Sout_Rdata_ram[127:8], Sout_DataRdy[1]};
`else
  assign fault = 1'b0;
  // TIMEOUT only matters when the watchdog is built in.
  logic w_unused;
  assign w_unused = ^{Sout_Rdata_ram[127:8], Sout_DataRdy[1], 32'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_main_mem_sequencer.sv
// Bench for main_mem_sequencer: a small `main` model answers the RAM port and done_port.
// Write and readback scoreboards are filled as preload bytes are offered.
module tb_main_mem_sequencer;

  localparam int unsigned BaseAddr = 256;
  localparam int unsigned NLoad    = 4;
  localparam int unsigned NRead    = 4;
  localparam int unsigned Timeout  = 50;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         go = 1'b0;
  logic         ld_valid = 1'b0;
  logic         ld_ready;
  logic [7:0]   ld_data = 8'd0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [7:0]   rd_data;
  logic         start_port;
  logic         done_port = 1'b0;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic [127:0] Sout_Rdata_ram = '0;
  logic [1:0]   Sout_DataRdy = 2'b00;
  logic         busy;
  logic         run_done;
  logic         fault;
  logic [31:0]  cycles;

  main_mem_sequencer #(
    .BASE_ADDR (BaseAddr),
    .LOAD_BYTES(NLoad),
    .READ_BYTES(NRead),
    .TIMEOUT   (Timeout)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .go             (go),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_data        (ld_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .start_port     (start_port),
    .done_port      (done_port),
    .S_oe_ram       (S_oe_ram),
    .S_we_ram       (S_we_ram),
    .S_addr_ram     (S_addr_ram),
    .S_Wdata_ram    (S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram (Sout_Rdata_ram),
    .Sout_DataRdy   (Sout_DataRdy),
    .busy           (busy),
    .run_done       (run_done),
    .fault          (fault),
    .cycles         (cycles)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] bytes;      // byte k in bits [8k+7:8k]
    int          gap;        // 1: ld_valid toggles every other cycle
    int          done_delay; // cycles from start_port to done_port
    int          done_hold;  // cycles done_port stays high
    int          rdy_delay;  // cycles from oe to DataRdy
    int          stall;      // cycles rd_ready held low per byte
    bit          noise;      // spurious DataRdy in RH, rd_ready high outside RH
    int          exp_cycles;
  } vec_t;
  vec_t vecs[4];

  // Scoreboards: {addr, data} of expected writes, expected readback bytes.
  logic [17:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  mem[1024];

  // Model configuration, written by the stimulus process.
  int cfg_done_delay = 1, cfg_done_hold = 1, cfg_rdy_delay = 1, cfg_stall = 0;
  bit cfg_noise = 1'b0, cfg_done_never = 1'b0;

  // Counters updated by the model.
  int start_cnt = 0, wr_cnt = 0, oe_cnt = 0, rd_cnt = 0, oe_idx = 0;
  int wr_first = 0, wr_last = 0, start_cyc = 0;
  int prev_cycles = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: scoreboard empty, got unexpected transfer", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {ld_ready, rd_valid, start_port, busy, run_done, fault}, 0);
    chk({tag, "_s_strobes"}, {S_oe_ram, S_we_ram, S_data_ram_size}, 0);
    chk({tag, "_s_addr"}, S_addr_ram, 0);
    chk({tag, "_s_wdata"}, S_Wdata_ram, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  // Model of `main` plus the readback consumer; samples mid-cycle, drives for the next edge.
  int done_wait = 0, done_left = 0, rdy_wait = 0, stall_left = 0;
  bit rh_active = 1'b0, rdy_pulse;
  logic [9:0] rd_addr = '0;
  logic [7:0] held = '0;
  logic [17:0] exp_w;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
    forever begin
      @(negedge clock);
      if (!reset) begin
        done_wait = 0; done_left = 0; rdy_wait = 0; rh_active = 1'b0;
        done_port = 1'b0; Sout_DataRdy = 2'b00; rd_ready = 1'b0;
      end else begin
        if (S_we_ram[0]) begin
          if (wq.size() == 0) fail_now("wr_unexpected");
          else begin
            exp_w = wq.pop_front();
            chk("wr_addr", S_addr_ram, {10'd0, exp_w[17:8]});
            chk("wr_data", S_Wdata_ram, {120'd0, exp_w[7:0]});
            chk("wr_size", S_data_ram_size, 14'd8);
          end
          mem[S_addr_ram[9:0]] = S_Wdata_ram[7:0];
          wr_cnt++;
          if (wr_cnt == 1) wr_first = cyc;
          wr_last = cyc;
        end
        // `main` finishes: it transforms the region in place.
        if (done_wait > 0) begin
          done_wait--;
          if (done_wait == 0) begin
            done_left = cfg_done_hold;
            for (int j = 0; j < int'(NRead); j++) mem[BaseAddr + j] = mem[BaseAddr + j] + 8'h11;
          end
        end
        if (start_port) begin
          start_cnt++;
          start_cyc = cyc;
          if (!cfg_done_never) done_wait = cfg_done_delay;
        end
        done_port = (done_left > 0);
        if (done_left > 0) done_left--;

        rdy_pulse = 1'b0;
        if (rdy_wait > 0) begin
          rdy_wait--;
          if (rdy_wait == 0) rdy_pulse = 1'b1;
        end
        if (S_oe_ram[0]) begin
          oe_cnt++;
          chk("rd_req_addr", S_addr_ram, 128'(BaseAddr + oe_idx));
          chk("rd_req_size", {S_we_ram, S_data_ram_size}, {2'b00, 14'd8});
          oe_idx++;
          rd_addr  = S_addr_ram[9:0];
          rdy_wait = cfg_rdy_delay;
        end
        Sout_Rdata_ram = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (rdy_pulse) begin
          Sout_DataRdy        = 2'b01;
          Sout_Rdata_ram[7:0] = mem[rd_addr];
        end else if (cfg_noise && rd_valid) begin
          Sout_DataRdy        = 2'b11;
          Sout_Rdata_ram[7:0] = 8'hEE;
        end else begin
          Sout_DataRdy = {cfg_noise, 1'b0};
        end

        if (rd_valid) begin
          if (rh_active) chk("rd_data_stable", rd_data, held);
          else begin
            rh_active  = 1'b1;
            stall_left = cfg_stall;
            held       = rd_data;
          end
          if (stall_left > 0) begin
            stall_left--;
            rd_ready = 1'b0;
          end else begin
            rd_ready  = 1'b1;
            rh_active = 1'b0;
            rd_cnt++;
            if (rq.size() == 0) fail_now("rd_unexpected");
            else chk("rd_data", rd_data, rq.pop_front());
          end
        end else begin
          rd_ready  = cfg_noise;
          rh_active = 1'b0;
        end
      end
    end
  end

  // Offer n bytes; expectations are pushed when each byte is first offered.
  task automatic load(input logic [31:0] bytes, input int gap, input int n);
    int k;
    int c;
    bit offered;
    logic acc;
    k = 0; c = 0; offered = 1'b0;
    while (k < n && c < 100) begin
      if (!offered) begin
        wq.push_back({10'(BaseAddr + k), bytes[8*k +: 8]});
        rq.push_back(bytes[8*k +: 8] + 8'h11);
        offered = 1'b1;
      end
      ld_valid = (gap == 0) || (c % 2 == 0);
      ld_data  = bytes[8*k +: 8];
      @(negedge clock);
      acc = ld_valid && ld_ready;
      tick();
      c++;
      if (acc) begin
        k++;
        offered = 1'b0;
      end
    end
    ld_valid = 1'b0;
    chk("load_bytes_accepted", k, n);
  endtask

  task automatic run_vec(input int i);
    int c;
    cfg_done_delay = vecs[i].done_delay; cfg_done_hold = vecs[i].done_hold;
    cfg_rdy_delay = vecs[i].rdy_delay; cfg_stall = vecs[i].stall; cfg_noise = vecs[i].noise;
    cfg_done_never = 1'b0;
    start_cnt = 0; wr_cnt = 0; oe_cnt = 0; rd_cnt = 0; oe_idx = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("cycles_kept_in_load", cycles, prev_cycles);
    chk("load_state", {busy, ld_ready, run_done}, 3'b110);
    load(vecs[i].bytes, vecs[i].gap, NLoad);
    c = 0;
    while (!run_done && c < 500) begin
      tick();
      c++;
    end
    chk("run_done_reached", run_done, 1'b1);
    chk("cycles", cycles, vecs[i].exp_cycles);
    chk("start_pulses", start_cnt, 1);
    chk("write_count", wr_cnt, NLoad);
    chk("read_requests", oe_cnt, NRead);
    chk("readback_count", rd_cnt, NRead);
    chk("readback_drained", rq.size(), 0);
    chk("fin_flags", {busy, fault, rd_valid, ld_ready}, 4'b0000);
    chk("fin_s_idle", {S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size}, 0);
    if (vecs[i].gap == 0) chk("writes_back_to_back", wr_last - wr_first, NLoad - 1);
    prev_cycles = vecs[i].exp_cycles;
  endtask

  initial begin
    vecs[0] = '{32'h0063051E, 0, 2, 5, 2, 3, 1'b0, 3};
    vecs[1] = '{32'h80FF55AA, 1, 1, 5, 1, 0, 1'b1, 2};
    vecs[2] = '{32'h78563412, 0, 7, 2, 3, 1, 1'b1, 8};
    vecs[3] = '{32'h03020100, 1, 4, 1, 1, 2, 1'b0, 5};

    #2;
    chk_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // Reset in the middle of a preload, then a clean reload from the base address.
    start_cnt = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    load(32'hDEADBEEF, 0, 2);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_mid_load");
    wq.delete();
    rq.delete();
    #5 reset = 1'b1;
    tick();
    chk("no_start_after_abort", start_cnt, 0);
    prev_cycles = 0;
    run_vec(0);

    // done_port never arrives.
    cfg_done_never = 1'b1;
    start_cnt = 0; oe_cnt = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    load(32'h11223344, 0, NLoad);
`ifdef SEQ_TIMEOUT_EN
    begin
      int c;
      c = 0;
      while (!fault && c < 200) begin
        tick();
        c++;
      end
      chk("fault_raised", fault, 1'b1);
      chk("fault_cycle", cyc - start_cyc, Timeout);
      chk("fault_cycles", cycles, Timeout);
      chk("fault_no_readback", oe_cnt, 0);
      chk("fault_flags", {busy, run_done}, 2'b00);
      rq.delete();
      prev_cycles = Timeout;
      run_vec(1);
    end
`else
    repeat (300) tick();
    chk("no_watchdog_fault", fault, 1'b0);
    chk("still_running", {busy, run_done}, 2'b10);
    chk("no_readback_without_done", oe_cnt, 0);
    chk("single_start", start_cnt, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_in_run");
    rq.delete();
    #5 reset = 1'b1;
    tick();
    cfg_done_never = 1'b0;
    prev_cycles = 0;
    run_vec(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
